saturate_pack_32to8: RTL and testbench

Narrows a stream of 32-bit signed words to 8-bit signed bytes with saturation and packs LANES bytes per output word under valid/ready handshakes. It is the inverse-direction companion of the team's 8-to-32 sign extender: it sits at the egress of the 32-bit datapath, ahead of byte-wide storage or links. A partial word is flushed early on `in_last`.

---
 rtl/saturate_pack_pkg.sv | 16 +
 rtl/saturate_pack_32to8_narrow.sv | 33 +++
 rtl/saturate_pack_32to8.sv | 123 ++++++++++++
 tb/tb_saturate_pack_32to8.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/saturate_pack_pkg.sv
// Shared constants and types for the 32-to-8 saturating packer.
// Saturation bounds, thresholds and the output-register state enum.
package saturate_pack_pkg;

  localparam logic signed [7:0] SAT_MAX = 8'sh7F;
  localparam logic signed [7:0] SAT_MIN = 8'sh80;

  localparam logic signed [31:0] SAT_HI = 32'sd127;
  localparam logic signed [31:0] SAT_LO = -32'sd128;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/saturate_pack_32to8_narrow.sv
// sat_narrow_32to8: combinational signed 32-bit to 8-bit saturator.
// Ports: word (in, 32) -> narrow (8), sat (1, clipping occurred).
module sat_narrow_32to8
  import saturate_pack_pkg::*;
(
  input  logic [31:0] word,
  output logic [7:0]  narrow,
  output logic        sat
);

  logic hi;
  logic lo;

  assign hi = $signed(word) > SAT_HI;
  assign lo = $signed(word) < SAT_LO;

  always_comb begin
    narrow = word[7:0];
    sat    = 1'b0;
    unique case (1'b1)
      hi: begin
        narrow = SAT_MAX;
        sat    = 1'b1;
      end
      lo: begin
        narrow = SAT_MIN;
        sat    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/saturate_pack_32to8.sv
// Saturating 32->8 narrower packing LANES bytes per output word.
// Ports: clk, reset (sync, active-high), in_valid/in_ready/in_data/
// in_last, out_valid/out_ready/out_data/out_keep/out_last.
// Macro SAT_PACK_STATUS_EN adds out_sat and sat_count (CNT_W).
module saturate_pack_32to8
  import saturate_pack_pkg::*;
#(
  parameter int LANES = 4
`ifdef SAT_PACK_STATUS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  output logic               out_last
`ifdef SAT_PACK_STATUS_EN
  ,
  output logic [LANES-1:0]   out_sat,
  output logic [CNT_W-1:0]   sat_count
`endif
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  ostate_t            state;
  logic [IDX_W-1:0]   idx;
  logic [8*LANES-1:0] acc;
  logic [8*LANES-1:0] word_nxt;
  logic [LANES-1:0]   keep_nxt;
  logic [7:0]         narrow;
  logic               sat;
  logic               accept;
  logic               complete;

  sat_narrow_32to8 u_narrow (
    .word   (in_data),
    .narrow (narrow),
    .sat    (sat)
  );

  assign out_valid = (state == FULL);
  // Ready ignores in_valid/in_last so it never loops back combinationally.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign complete  = accept &&
    ((idx == IDX_W'(LANES - 1)) || in_last);

  // Lanes above idx are still zero from the last clear,
  // which gives the 0x00 fill for flushed partial words.
  always_comb begin
    word_nxt = acc;
    word_nxt[{idx, 3'b000} +: 8] = narrow;
    for (int i = 0; i < LANES; i++) begin
      keep_nxt[i] = (IDX_W'(i) <= idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      idx      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else begin
      if (complete) begin
        state    <= FULL;
        idx      <= '0;
        acc      <= '0;
        out_data <= word_nxt;
        out_keep <= keep_nxt;
        out_last <= in_last;
      end else begin
        if (accept) begin
          idx <= idx + 1'b1;
          acc <= word_nxt;
        end
        if (out_valid && out_ready) begin
          state <= EMPTY;
        end
      end
    end
  end

`ifdef SAT_PACK_STATUS_EN
  logic [LANES-1:0] sat_acc;
  logic [LANES-1:0] sat_nxt;

  always_comb begin
    sat_nxt      = sat_acc;
    sat_nxt[idx] = sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_acc   <= '0;
      out_sat   <= '0;
      sat_count <= '0;
    end else begin
      if (complete) begin
        sat_acc <= '0;
        out_sat <= sat_nxt;
      end else if (accept) begin
        sat_acc <= sat_nxt;
      end
      if (accept && sat && (sat_count != '1)) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_saturate_pack_32to8.sv
// Directed bench for saturate_pack_32to8 (LANES = 4).
// Honors SAT_PACK_STATUS_EN, using CNT_W = 2 when defined.
module tb_saturate_pack_32to8;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
`ifdef SAT_PACK_STATUS_EN
  logic [3:0]  out_sat;
  logic [1:0]  sat_count;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

`ifdef SAT_PACK_STATUS_EN
  saturate_pack_32to8 #(.LANES(LANES), .CNT_W(2)) dut (
`else
  saturate_pack_32to8 #(.LANES(LANES)) dut (
`endif
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
`ifdef SAT_PACK_STATUS_EN
    ,
    .out_sat   (out_sat),
    .sat_count (sat_count)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic ok;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_keep", out_keep, 0);
    check("rst_last", out_last, 0);
    check("rst_ready", in_ready, 1);
`ifdef SAT_PACK_STATUS_EN
    check("rst_sat", out_sat, 0);
    check("rst_cnt", sat_count, 0);
`endif
    reset = 1'b0;

    send(32'd1, 0);
    send(32'd2, 0);
    send(32'd3, 0);
    check("p1_novalid", out_valid, 0);
    send(32'd4, 0);
    check("p1_valid", out_valid, 1);
    check("p1_data", out_data, 32'h04030201);
    check("p1_keep", out_keep, 4'hF);
    check("p1_last", out_last, 0);

    send(32'h00000200, 0);
    check("sat_drain", out_valid, 0);
    send(32'hFFFFFE00, 0);
    send(32'd127, 0);
    send(32'hFFFFFF80, 0);
    check("sat_valid", out_valid, 1);
    check("sat_data", out_data, 32'h807F807F);
    check("sat_keep", out_keep, 4'hF);
`ifdef SAT_PACK_STATUS_EN
    check("sat_flags", out_sat, 4'b0011);
    check("sat_cnt", sat_count, 2);
`endif

    send(32'd5, 0);
    send(32'd6, 1);
    check("fl_valid", out_valid, 1);
    check("fl_data", out_data, 32'h00000605);
    check("fl_keep", out_keep, 4'h3);
    check("fl_last", out_last, 1);
    send(32'd7, 0);
    send(32'd8, 0);
    send(32'd9, 0);
    send(32'd10, 0);
    check("nx_data", out_data, 32'h0A090807);
    check("nx_keep", out_keep, 4'hF);
    check("nx_last", out_last, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd11;
    in_last   = 1'b0;
    #1;
    check("bp_ready", in_ready, 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (!(out_valid === 1'b1 && out_data === 32'h0A090807 &&
            out_keep === 4'hF && in_ready === 1'b0)) ok = 1'b0;
    end
    check("bp_stable", ok, 1);
    out_ready = 1'b1;
    in_last   = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("rl_valid", out_valid, 1);
    check("rl_data", out_data, 32'h0000000B);
    check("rl_keep", out_keep, 4'h1);
    check("rl_last", out_last, 1);

    send(32'd20, 0);
    check("mr_drain", out_valid, 0);
    send(32'd21, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_keep", out_keep, 0);
    send(32'd30, 0);
    send(32'd31, 0);
    send(32'd32, 0);
    check("mr_nopart", out_valid, 0);
    send(32'd33, 0);
    check("mr_valid2", out_valid, 1);
    check("mr_data2", out_data, 32'h21201F1E);
    check("mr_keep2", out_keep, 4'hF);

`ifdef SAT_PACK_STATUS_EN
    check("cnt_cleared", sat_count, 0);
    for (int i = 0; i < 4; i++) send(32'd1000, 0);
    check("cs_flags", out_sat, 4'hF);
    check("cs_data", out_data, 32'h7F7F7F7F);
    send(32'd1000, 1);
    check("cs_keep", out_keep, 4'h1);
    check("cs_flag1", out_sat, 4'h1);
    check("cs_stick", sat_count, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
